// File: rtl/key_press_decoder.sv
// key_press_decoder: classifies debounced key gestures as short, double or
// long presses, and emits auto-repeat ticks while a long press is held.
// All gesture outputs are single-cycle pulses taken straight from registers.
module key_press_decoder #(
    parameter int unsigned LONG_CNT   = 32'd50_000_000,
    parameter int unsigned DBL_GAP    = 32'd15_000_000,
    parameter int unsigned REPEAT_CNT = 32'd10_000_000,
    parameter int unsigned CNT_W      = 32'd26
) (
    input  logic clk,
    input  logic rst,
    input  logic key_flag,
    input  logic key_state,
    output logic short_press,
    output logic double_press,
    output logic long_press,
    output logic repeat_tick,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HOLD1 = 3'd1,
        WAIT2 = 3'd2,
        HOLD2 = 3'd3,
        LONG  = 3'd4
    } state_t;

    // Terminal counter values: each timed phase ends on the cycle where the
    // counter reaches its period minus one.
    localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CNT - 32'd1);
    localparam logic [CNT_W-1:0] DBL_TERM  = CNT_W'(DBL_GAP - 32'd1);
    localparam logic [CNT_W-1:0] REP_TERM  = CNT_W'(REPEAT_CNT - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(32'd0);

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             key_state_r;
    logic             rel_s;
    logic             cnt_clr_s;

    logic             short_next_s;
    logic             double_next_s;
    logic             long_next_s;
    logic             repeat_next_s;

    logic             short_press_r;
    logic             double_press_r;
    logic             long_press_r;
    logic             repeat_tick_r;

    // Release is a falling edge of the registered level, so the one-cycle lag
    // of key_state behind key_flag never looks like a release.
    assign rel_s = key_state_r & ~key_state;

    // Next-state, counter and output-pulse decode.
    always_comb begin
        next_state_s  = state_r;
        cnt_next_s    = CNT_ZERO;
        cnt_clr_s     = 1'b0;
        short_next_s  = 1'b0;
        double_next_s = 1'b0;
        long_next_s   = 1'b0;
        repeat_next_s = 1'b0;

        case (state_r)
            IDLE: begin
                if (key_flag) begin
                    next_state_s = HOLD1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            HOLD1: begin
                // Reaching the long threshold takes priority over a release
                // seen on the same edge.
                if (cnt_r == LONG_TERM) begin
                    next_state_s = LONG;
                    long_next_s  = 1'b1;
                end else if (rel_s) begin
                    next_state_s = WAIT2;
                end else begin
                    next_state_s = HOLD1;
                end
            end
            WAIT2: begin
                // A second press on the expiry edge still counts as double.
                if (key_flag) begin
                    next_state_s  = HOLD2;
                    double_next_s = 1'b1;
                end else if (cnt_r == DBL_TERM) begin
                    next_state_s = IDLE;
                    short_next_s = 1'b1;
                end else begin
                    next_state_s = WAIT2;
                end
            end
            HOLD2: begin
                if (rel_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = HOLD2;
                end
            end
            LONG: begin
                // Level test on key_state; a release beats a repeat terminal.
                if (!key_state) begin
                    next_state_s = IDLE;
                end else if (cnt_r == REP_TERM) begin
                    next_state_s  = LONG;
                    repeat_next_s = 1'b1;
                    cnt_clr_s     = 1'b1;
                end else begin
                    next_state_s = LONG;
                end
            end
            default: begin
                // Unreachable encodings recover to IDLE.
                next_state_s = IDLE;
            end
        endcase

        // Counter clears on every state change and at the repeat terminal;
        // it only advances in the timed states.
        if ((next_state_s != state_r) || cnt_clr_s) begin
            cnt_next_s = CNT_ZERO;
        end else if ((state_r == HOLD1) || (state_r == WAIT2) || (state_r == LONG)) begin
            cnt_next_s = cnt_r + CNT_ONE;
        end else begin
            cnt_next_s = CNT_ZERO;
        end
    end

    // State, counter, key level history and output pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= IDLE;
            cnt_r          <= CNT_ZERO;
            key_state_r    <= 1'b0;
            short_press_r  <= 1'b0;
            double_press_r <= 1'b0;
            long_press_r   <= 1'b0;
            repeat_tick_r  <= 1'b0;
        end else begin
            state_r        <= next_state_s;
            cnt_r          <= cnt_next_s;
            key_state_r    <= key_state;
            short_press_r  <= short_next_s;
            double_press_r <= double_next_s;
            long_press_r   <= long_next_s;
            repeat_tick_r  <= repeat_next_s;
        end
    end

    assign short_press  = short_press_r;
    assign double_press = double_press_r;
    assign long_press   = long_press_r;
    assign repeat_tick  = repeat_tick_r;
    assign busy         = (state_r != IDLE);

endmodule

// File: tb/tb_key_press_decoder.sv
// Bench for key_press_decoder: each gesture is planned as per-edge input
// arrays plus expected-output arrays derived from the gesture timing rules,
// then played against the DUT edge by edge.
module tb_key_press_decoder;

    localparam int LONG = 20;
    localparam int DBL  = 10;
    localparam int REP  = 5;
    localparam int LEN  = 128;

    logic clk = 1'b0;
    logic rst;
    logic key_flag;
    logic key_state;
    logic short_press;
    logic double_press;
    logic long_press;
    logic repeat_tick;
    logic busy;

    int checks   = 0;
    int failures = 0;

    bit kf_a [LEN];
    bit ks_a [LEN];
    bit e_sh [LEN];
    bit e_db [LEN];
    bit e_lg [LEN];
    bit e_rp [LEN];
    bit e_bz [LEN];
    int seg_len;

    always #5 clk = ~clk;

    key_press_decoder #(
        .LONG_CNT   (LONG),
        .DBL_GAP    (DBL),
        .REPEAT_CNT (REP),
        .CNT_W      (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_flag     (key_flag),
        .key_state    (key_state),
        .short_press  (short_press),
        .double_press (double_press),
        .long_press   (long_press),
        .repeat_tick  (repeat_tick),
        .busy         (busy)
    );

    task automatic chk(input string tag, input string sig, input int edge_n,
                       input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s.%s edge=%0d observed=%0b expected=%0b", tag, sig, edge_n, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int edge_n, input logic sh, input logic db,
                           input logic lg, input logic rp, input logic bz);
        chk(tag, "short_press",  edge_n, short_press,  sh);
        chk(tag, "double_press", edge_n, double_press, db);
        chk(tag, "long_press",   edge_n, long_press,   lg);
        chk(tag, "repeat_tick",  edge_n, repeat_tick,  rp);
        chk(tag, "busy",         edge_n, busy,         bz);
    endtask

    // Plan one gesture starting at edge 2. Press 1: key_state high on edges
    // 2+lag .. 2+d1-1, released on edge 2+d1. gap in 1..DBL adds a second
    // press whose key_flag lands gap edges after the release.
    task automatic plan(input int lag, input int d1, input int gap,
                        input int lag2, input int d2, input int spur);
        int f, r, x, g, fin, hi;
        for (int i = 0; i < LEN; i++) begin
            kf_a[i] = 1'b0; ks_a[i] = 1'b0;
            e_sh[i] = 1'b0; e_db[i] = 1'b0; e_lg[i] = 1'b0;
            e_rp[i] = 1'b0; e_bz[i] = 1'b0;
        end
        f = 2;
        r = f + d1;
        kf_a[f] = 1'b1;
        for (int e = f + lag; e < r; e++) ks_a[e] = 1'b1;
        if (d1 >= LONG) begin
            // Long fires LONG edges after the press edge; the key is seen low
            // no earlier than the edge after that.
            e_lg[f + LONG] = 1'b1;
            x = (r > f + LONG) ? r : f + LONG + 1;
            for (int t = f + LONG + REP; t < x; t += REP) e_rp[t] = 1'b1;
            fin = x;
            hi  = x - 1;
        end else if (gap >= 1 && gap <= DBL) begin
            g = r + gap;
            kf_a[g] = 1'b1;
            e_db[g] = 1'b1;
            for (int e = g + lag2; e < g + d2; e++) ks_a[e] = 1'b1;
            fin = g + d2;
            hi  = r - 1;
        end else begin
            e_sh[r + DBL] = 1'b1;
            fin = r + DBL;
            hi  = r - 1;
        end
        for (int e = f; e < fin; e++) e_bz[e] = 1'b1;
        // A stray key_flag while the first press is held must change nothing.
        if (spur != 0 && hi >= f + 1) kf_a[int'($urandom_range(hi, f + 1))] = 1'b1;
        seg_len = fin + 3;
    endtask

    task automatic run_seg(input string tag);
        for (int e = 0; e < seg_len; e++) begin
            key_flag  = kf_a[e];
            key_state = ks_a[e];
            @(posedge clk);
            #1;
            chk_all(tag, e, e_sh[e], e_db[e], e_lg[e], e_rp[e], e_bz[e]);
        end
        key_flag  = 1'b0;
        key_state = 1'b0;
    endtask

    // Start a hold, assert reset 'at' edges after the press edge, then keep
    // the key held: nothing may fire until a fresh key_flag.
    task automatic reset_test(input string tag, input int at);
        key_flag  = 1'b1;
        key_state = 1'b1;
        @(posedge clk);
        #1;
        key_flag = 1'b0;
        for (int e = 1; e <= at; e++) begin
            @(posedge clk);
            #1;
        end
        chk(tag, "busy_pre", at, busy, 1'b1);
        chk(tag, "long_pre", at, long_press, (at == LONG) ? 1'b1 : 1'b0);
        #1 rst = 1'b0;
        #1;
        chk_all({tag, "_in_rst"}, at, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        for (int e = 0; e < 30; e++) begin
            @(posedge clk);
            #1;
            chk_all({tag, "_held"}, e, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        key_state = 1'b0;
        for (int e = 0; e < 3; e++) begin
            @(posedge clk);
            #1;
            chk_all({tag, "_rel"}, e, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int lag, d1, gap, lag2, d2, spur;
        rst       = 1'b0;
        key_flag  = 1'b0;
        key_state = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_all("idle", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        plan(0, 8, -1, 0, 1, 0);   run_seg("short");
        plan(0, 5, 6, 0, 4, 0);    run_seg("double");
        plan(0, 37, -1, 0, 1, 0);  run_seg("long_repeat");
        plan(0, 20, -1, 0, 1, 0);  run_seg("rel_at_long_term");
        plan(0, 5, 10, 0, 3, 0);   run_seg("dbl_at_expiry");
        plan(1, 25, -1, 0, 1, 0);  run_seg("lag_long");
        plan(1, 8, -1, 0, 1, 1);   run_seg("lag_short_spur");
        plan(0, 30, -1, 0, 1, 1);  run_seg("long_spur");
        plan(0, 4, 3, 1, 12, 1);   run_seg("double_long_hold2");

        reset_test("rst_hold1", 12);
        plan(0, 8, -1, 0, 1, 0);   run_seg("short_after_rst");
        reset_test("rst_long", LONG);
        plan(0, 5, 2, 0, 3, 0);    run_seg("double_after_rst");

        for (int n = 0; n < 40; n++) begin
            lag  = int'($urandom_range(1, 0));
            d1   = int'($urandom_range(30, lag + 1));
            gap  = ($urandom_range(1, 0) == 1) ? int'($urandom_range(14, 1)) : -1;
            lag2 = int'($urandom_range(1, 0));
            d2   = int'($urandom_range(8, lag2 + 1));
            spur = int'($urandom_range(1, 0));
            plan(lag, d1, gap, lag2, d2, spur);
            run_seg("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_press_decoder.md
Name: key_press_decoder

Overview:
- Consumes the debounced key outputs of the key debounce stage: `key_flag` (one-cycle press pulse) and `key_state` (1 while the key is debounced-down).
- Classifies each key gesture as short press, double press or long press, and emits auto-repeat ticks while a long press is held.
- All outputs are single-cycle registered pulses that feed control logic such as counters, mode selectors and display drivers.

Parameters:
- LONG_CNT, 50_000_000: hold time in clk cycles (1 s at 50 MHz) before a press is classified as long.
- DBL_GAP, 15_000_000: maximum time in clk cycles from release to a second press for a double press (300 ms).
- REPEAT_CNT, 10_000_000: auto-repeat period in clk cycles during a long hold (200 ms).
- CNT_W, 26: width of the internal counter; must hold max(LONG_CNT, DBL_GAP, REPEAT_CNT) - 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- key_flag  in  1  one-cycle pulse on a debounced key press.
- key_state  in  1  debounced key level; 1 = pressed. May rise up to 1 cycle after key_flag.
- short_press  out  1  one-cycle pulse: single short press confirmed.
- double_press  out  1  one-cycle pulse: second press arrived within DBL_GAP.
- long_press  out  1  one-cycle pulse: hold reached LONG_CNT.
- repeat_tick  out  1  one-cycle pulse every REPEAT_CNT cycles while a long press is held.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE, cnt = 0, key_state_r = 0.
  - short_press, double_press, long_press and repeat_tick are all 0; busy = 0.
- Release detection:
  - key_state_r is key_state registered once.
  - rel = key_state_r & ~key_state.
  - Release is edge-based so that the 1-cycle lag of key_state behind key_flag is never seen as a release.
- Counter:
  - cnt clears to 0 on every state change.
  - cnt increments by 1 each cycle while in HOLD1, WAIT2 or LONG.
  - cnt holds 0 in IDLE and HOLD2.
  - No wrap-around: cnt is cleared at each terminal value.
- FSM states: IDLE, HOLD1, WAIT2, HOLD2, LONG. Transitions are evaluated at each rising edge.
  - IDLE: key_flag=1 -> HOLD1. Otherwise stay.
  - HOLD1:
    - cnt==LONG_CNT-1 -> LONG; long_press=1 for the next cycle.
    - Else rel=1 -> WAIT2.
    - Else stay.
    - If both conditions occur together, long wins.
  - WAIT2:
    - key_flag=1 -> HOLD2; double_press=1 for the next cycle.
    - Else cnt==DBL_GAP-1 -> IDLE; short_press=1 for the next cycle.
    - If key_flag and expiry occur on the same edge, double wins.
  - HOLD2:
    - rel=1 -> IDLE. Otherwise stay.
    - No long detection on the second press; a held second press produces no further pulses.
  - LONG:
    - key_state=0 -> IDLE (level test; key_state is guaranteed high on entry).
    - Else cnt==REPEAT_CNT-1 -> repeat_tick=1 for the next cycle, cnt cleared, stay in LONG.
    - If release and repeat terminal occur on the same edge, release wins and no tick is emitted.
- Latency, counting edge 0 as the edge that samples the relevant input:
  - long_press rises on edge LONG_CNT after the edge sampling key_flag.
  - First repeat_tick rises REPEAT_CNT edges after long_press rises; subsequent ticks follow every REPEAT_CNT edges.
  - short_press rises on edge DBL_GAP after the edge sampling rel=1.
  - double_press rises on the edge that samples the second key_flag.
- Output pulses:
  - Every output pulse is exactly 1 cycle wide.
  - At most one of short_press, double_press and long_press is asserted per gesture.
  - Outputs are mutually exclusive in any given cycle.
- busy = (state != IDLE), driven directly from the state register.
- key_flag while in HOLD1, HOLD2 or LONG is ignored; the upstream stage cannot produce it, but the ignore behaviour is required.
- Reset mid-gesture: everything returns immediately to reset values. The gesture in progress produces no pulse, and a key still held after reset is ignored until the next key_flag.

Test Plan (LONG_CNT=20, DBL_GAP=10, REPEAT_CNT=5):
- Short press:
  - Stimulus: key_flag pulse, key_state high for 8 cycles then low.
  - Required: short_press one cycle, exactly 10 edges after release; no other pulses; busy then falls.
- Double press:
  - Stimulus: press 5 cycles, release, second key_flag 6 cycles after release, held 4 cycles.
  - Required: double_press one cycle, on the edge sampling the second key_flag; short_press never asserted.
- Long press with repeat:
  - Stimulus: key_flag pulse, key_state held 37 cycles.
  - Required: long_press on edge 20; repeat_tick at +5, +10 and +15 edges after it; 0 after release; busy low 1 cycle after release.
- Boundaries:
  - Release sampled on the same edge as cnt==19 in HOLD1 -> long_press, then IDLE.
  - Second key_flag on the same edge as WAIT2 cnt==9 -> double_press only.
- Async reset mid-gesture:
  - Stimulus: rst low during HOLD1 at cnt=12 while key_state stays high.
  - Required: all outputs 0 immediately; no pulse after rst release until a new key_flag arrives.
- key_state lag:
  - Stimulus: key_state rises 1 cycle after key_flag.
  - Required: no false release; a 25-cycle hold still yields long_press on edge 20.
